// File: rtl/ws2812_frame_reader.sv
// WS2812 frame reader: walks the colour RAM from address 0 to NLEDS-1 and
// serialises each word MSB first onto a one-wire LED data line, then holds
// the line low for the latch period and pulses done.
// Optional build macro WS2812_GRB_EN: reorders RAM RGB words into strip GRB
// order as each word is loaded into the shift register.
module ws2812_frame_reader #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 24,
    parameter int unsigned NLEDS = 14,
    parameter int unsigned TBIT  = 62,
    parameter int unsigned T0H   = 20,
    parameter int unsigned T1H   = 40,
    parameter int unsigned TRST  = 3000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_data,
    output logic          dout,
    output logic          busy,
    output logic          done
);

    // One counter serves both the bit period and the latch period.
    localparam int unsigned TW = $clog2(TRST > TBIT ? TRST : TBIT) + 1;
    localparam int unsigned BW = $clog2(DW);

    localparam logic [TW-1:0] TBitLast = TW'(TBIT - 1);
    localparam logic [TW-1:0] TRstLast = TW'(TRST - 1);
    localparam logic [AW-1:0] IdxLast  = AW'(NLEDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSend,
        StLatch,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] load_word;
    logic [TW-1:0] hi_len;

    // Colour order conversion applied on load.
    always_comb begin
`ifdef WS2812_GRB_EN
        load_word = {ram_data[15:8], ram_data[23:16], ram_data[7:0]};
`else
        load_word = ram_data;
`endif
    end

    // Next-state logic: fetch/load/send per pixel, then latch and done.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d = load_word;
                bit_d   = BW'(DW - 1);
                tcnt_d  = '0;
                state_d = StSend;
            end
            StSend: begin
                if (tcnt_q == TBitLast) begin
                    tcnt_d  = '0;
                    shift_d = shift_q << 1;
                    if (bit_q == '0) begin
                        if (idx_q == IdxLast) begin
                            // Address parks at 0 while the latch runs.
                            idx_d   = '0;
                            state_d = StLatch;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = StFetch;
                        end
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StLatch: begin
                if (tcnt_q == TRstLast) begin
                    tcnt_d  = '0;
                    state_d = StDone;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StDone: begin
                // A held start chains straight into the next frame.
                state_d = start ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state so reset forces dout low at once.
    always_comb begin
        hi_len   = shift_q[DW-1] ? TW'(T1H) : TW'(T0H);
        dout     = 1'b0;
        ram_rd   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ram_addr = idx_q;
        if (state_q == StSend) begin
            dout = (tcnt_q < hi_len);
        end
        if (state_q == StFetch || state_q == StLoad || state_q == StSend) begin
            ram_rd = 1'b1;
        end
        if (state_q != StIdle) begin
            busy = 1'b1;
        end
        if (state_q == StDone) begin
            done = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_reader.sv
// Scoreboard bench for ws2812_frame_reader: stimulus pushes expected pulse
// widths, read addresses and sampled values; monitors pop and compare.
module tb_ws2812_frame_reader;

    localparam int AW    = 6;
    localparam int DW    = 24;
    localparam int NLEDS = 14;
    localparam int TBIT  = 62;
    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int TRST  = 3000;
    localparam int FRAME = NLEDS * (24 * TBIT + 2) + TRST + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data = '0;
    logic          dout;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [NLEDS];

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t pulse_q[$];
    exp_t snap_q[$];
    exp_t rst_q[$];
    int   addr_q[$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    ws2812_frame_reader #(
        .AW   (AW),
        .DW   (DW),
        .NLEDS(NLEDS),
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H),
        .TRST (TRST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ram_rd  (ram_rd),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .dout    (dout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read colour RAM model.
    always @(posedge clk) begin
        if (ram_rd && int'(ram_addr) < NLEDS) ram_data <= ram[int'(ram_addr)];
    end

    function automatic void cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int sig_val(input string n);
        if (n == "dout") return int'(dout);
        if (n == "busy") return int'(busy);
        if (n == "ram_rd") return int'(ram_rd);
        if (n == "done") return int'(done);
        if (n == "ram_addr") return int'(ram_addr);
        return -1;
    endfunction

    function automatic void sb_pulse(input string name, input int act);
        exp_t e;
        if (pulse_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected %s: got %0d, expected no event (cycle %0d)", name, act, cyc);
            return;
        end
        e = pulse_q.pop_front();
        if (e.name != name) begin
            n_vec++;
            n_fail++;
            $display("FAIL event order: got %s=%0d, expected %s=%0d (cycle %0d)",
                     name, act, e.name, e.val, cyc);
        end else begin
            cmp(name, act, e.val);
        end
    endfunction

    function automatic void exp_pulse(input string n, input int v);
        exp_t e;
        e.name = n;
        e.val  = v;
        pulse_q.push_back(e);
    endfunction

    function automatic void exp_snap(input string n, input int v);
        exp_t e;
        e.name = n;
        e.val  = v;
        snap_q.push_back(e);
    endfunction

    function automatic void exp_rst(input string n, input int v);
        exp_t e;
        e.name = n;
        e.val  = v;
        rst_q.push_back(e);
    endfunction

    function automatic logic [23:0] exp_word(input logic [23:0] w);
`ifdef WS2812_GRB_EN
        return {w[15:8], w[23:16], w[7:0]};
`else
        return w;
`endif
    endfunction

    // Expected events for one frame; stops before (abort_pix, abort_bit) if given.
    task automatic push_frame(input int abort_pix, input int abort_bit, input bit with_done);
        logic [23:0] w;
        int          h;
        exp_pulse("first_rise", 3);
        for (int p = 0; p < NLEDS; p++) begin
            addr_q.push_back(p);
            w = exp_word(ram[p]);
            for (int b = 23; b >= 0; b--) begin
                if (p == abort_pix && b == abort_bit) return;
                h = w[b] ? T1H : T0H;
                exp_pulse("high", h);
                if (!(p == NLEDS - 1 && b == 0)) exp_pulse("low", TBIT - h + ((b == 0) ? 2 : 0));
            end
        end
        if (with_done) exp_pulse("done", FRAME);
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        exp_rst("dout", 0);
        exp_rst("busy", 0);
        exp_rst("ram_rd", 0);
        exp_rst("done", 0);
        exp_rst("ram_addr", 0);
        rst_n = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asynchronous reset monitor: outputs must clear without a clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge rst_n);
            #1;
            while (rst_q.size() > 0) begin
                e = rst_q.pop_front();
                cmp({"reset ", e.name}, sig_val(e.name), e.val);
            end
        end
    end

    // Output monitor: measures dout pulses, done, RAM read addresses, snapshots.
    initial begin
        exp_t          e;
        int            frame_k   = 0;
        int            rise_c    = 0;
        int            fall_c    = 0;
        bit            have_fall = 1'b0;
        logic          prev_dout = 1'b0;
        logic          prev_busy = 1'b0;
        logic          prev_rd   = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                e = snap_q.pop_front();
                cmp(e.name, sig_val(e.name), e.val);
            end
            if (!rst_n || !mon_en) begin
                prev_dout = 1'b0;
                prev_busy = 1'b0;
                prev_rd   = 1'b0;
                have_fall = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    frame_k   = cyc;
                    have_fall = 1'b0;
                end
                if (dout && !prev_dout) begin
                    if (!have_fall) sb_pulse("first_rise", cyc + 1 - frame_k);
                    else sb_pulse("low", cyc - fall_c);
                    rise_c = cyc;
                end
                if (!dout && prev_dout) begin
                    sb_pulse("high", cyc - rise_c);
                    fall_c    = cyc;
                    have_fall = 1'b1;
                end
                if (done) begin
                    sb_pulse("done", cyc + 1 - frame_k);
                    frame_k   = cyc + 1;
                    have_fall = 1'b0;
                end
                if (ram_rd && (!prev_rd || ram_addr != prev_addr)) begin
                    if (addr_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected read: got addr %0d, expected none", ram_addr);
                    end else begin
                        cmp("ram_addr", int'(ram_addr), addr_q.pop_front());
                    end
                end
                prev_dout = dout;
                prev_busy = busy;
                prev_rd   = ram_rd;
                prev_addr = ram_addr;
            end
        end
    end

    // Stimulus.
    initial begin
        int kb;
        int ka;
        int k2;
        int kd;
        int spam[5] = '{100, 5000, 20000, 21000, 23000};
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NLEDS; i++) ram[i] = '0;
        #2;
        do_reset(5);
        mon_en = 1'b1;

        // Idle after reset.
        repeat (100) @(negedge clk);
        exp_snap("dout", 0);
        exp_snap("busy", 0);
        exp_snap("ram_rd", 0);
        exp_snap("done", 0);
        exp_snap("ram_addr", 0);
        @(negedge clk);

        // Frame A: all pixels 24'hFF0000.
        for (int i = 0; i < NLEDS; i++) ram[i] = 24'hFF0000;
        push_frame(-1, 0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        ka = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        exp_snap("busy", 1);
        goto(ka + FRAME + 10);
        exp_snap("busy", 0);
        exp_snap("done", 0);
        exp_snap("dout", 0);
        @(negedge clk);

        // Frame B: mixed data, start spammed, then held into chained frame C.
        for (int i = 0; i < NLEDS; i++) ram[i] = '0;
        ram[0] = 24'h800001;
        push_frame(-1, 0, 1'b1);
        push_frame(5, 12, 1'b0);
        @(negedge clk);
        start = 1'b1;
        kb = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        foreach (spam[i]) begin
            goto(kb + spam[i]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        goto(kb + 23500);
        start = 1'b1;
        goto(kb + FRAME + 4);
        start = 1'b0;
        k2 = kb + FRAME;

        // Abort frame C in pixel 5, bit 12 high phase.
        goto(k2 + 8139);
        exp_snap("dout", 1);
        @(negedge clk);
        #3;
        do_reset(3);
        exp_snap("ram_addr", 0);
        exp_snap("busy", 0);
        @(negedge clk);

        // Frame D restarts at pixel 0; abort early.
        push_frame(0, 23, 1'b0);
        @(negedge clk);
        start = 1'b1;
        kd = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        goto(kd + 15);
        #3;
        do_reset(3);
        repeat (50) @(negedge clk);

        foreach (pulse_q[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL missing %s: got nothing, expected %0d", pulse_q[i].name, pulse_q[i].val);
        end
        foreach (addr_q[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL missing read: got nothing, expected addr %0d", addr_q[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_reader.md
Name: ws2812_frame_reader

Overview:
- Reader side of the 14-entry, 24-bit LED colour RAM. The bus side writes colours into that RAM.
- This block walks the RAM from address 0 to NLEDS-1 on request and serialises each 24-bit word onto a single WS2812-style one-wire output.
- It ends each frame with a latch (reset) low period and then returns to idle.
- Sits between the colour RAM read port and the aquarium LED strip pin.

Parameters:
- AW, 6, RAM address width.
- DW, 24, colour word width; fixed at 24 for WS2812.
- NLEDS, 14, number of RAM entries and pixels per frame.
- TBIT, 62, clocks per bit period (1.25 us at 50 MHz).
- T0H, 20, high clocks for a 0 bit.
- T1H, 40, high clocks for a 1 bit.
- TRST, 3000, low clocks for the frame latch (60 us at 50 MHz).

Ports:
- clk, input, 1, global clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, frame request; sampled only in IDLE.
- ram_rd, output, 1, drives the RAM rw line. 1 = read. High from FETCH of pixel 0 through the last SEND.
- ram_addr, output, AW, RAM read address.
- ram_data, input, DW, RAM registered read data. Valid the cycle after a clk edge with ram_rd=1.
- dout, output, 1, serial LED data line.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse at end of frame latch.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, dout=0, ram_rd=0, ram_addr=0, busy=0, done=0, pixel index=0, bit counter=0, timing counter=0. Reset mid-frame aborts immediately; dout goes low with no further bits. The next frame restarts at pixel 0.
- IDLE: start=1 at edge k -> FETCH. busy=1 from k+1.
- FETCH (1 cycle): ram_rd=1, ram_addr=index -> LOAD.
- LOAD (1 cycle): ram_data captured into the 24-bit shift register at the end of the cycle. Bit counter=23, timing counter=0. -> SEND.
- SEND: output the MSB of the shift register.
  - dout=1 while timing counter < (bit ? T1H : T0H), else 0.
  - Timing counter runs 0..TBIT-1.
  - At TBIT-1: shift left, decrement the bit counter, reset the timing counter.
  - After bit 0 completes: if index < NLEDS-1, increment index -> FETCH; otherwise -> LATCH with ram_rd=0.
- Latency and gaps:
  - First dout rise occurs on cycle k+3.
  - Gap between pixels is exactly 2 low cycles (FETCH and LOAD).
  - A frame of 14 pixels spans 14*(24*TBIT+2) + TRST + 1 cycles after k.
- LATCH: dout=0 for TRST cycles. Then done=1 for exactly one cycle with busy still 1, then IDLE with busy=0.
- start while busy: ignored, not queued. start held high in IDLE: a new frame begins the cycle after done falls.
- RAM writes to any address during a frame: the reader returns whatever is at the address when FETCH occurs. No coherence is guaranteed for the current frame.
- Index wrap: index never exceeds NLEDS-1. ram_addr returns to 0 in LATCH.
- Bit order: MSB first, word[23] sent first.

Optional Feature:
- Macro WS2812_GRB_EN.
- Defined: on LOAD the shift register is loaded as {ram_data[15:8], ram_data[23:16], ram_data[7:0]}. This converts RAM RGB to strip GRB order.
- Undefined: ram_data is loaded unmodified.

Test Plan:
- Reset then idle: rst_n low 5 cycles, release, start=0 for 100 cycles -> dout=0, busy=0, ram_rd=0, done never asserts.
- Single frame with all RAM entries 24'hFF0000, GRB disabled, start pulse at cycle k:
  - dout first rises at k+3.
  - Each pixel sends 8 pulses of 40 high / 22 low, then 16 pulses of 20 high / 42 low.
  - ram_addr steps 0..13.
  - done pulses exactly once at k+14*(24*62+2)+3000+1.
- Same frame with WS2812_GRB_EN defined -> the first 8 bits of each pixel are 0-pulses (20 high) and bits 8..15 are 1-pulses (40 high).
- Mixed data: ram[0]=24'h800001, others 0 -> pixel 0 sends a 1-pulse, 22 0-pulses, then a 1-pulse. Exactly 2 low cycles separate pixel 0 bit 0 end from pixel 1 first rise.
- start asserted repeatedly during SEND and LATCH -> no restart, single done. Holding start high -> the second frame's FETCH occurs the cycle after done.
- Asynchronous reset asserted mid-way through pixel 5 bit 12 high phase -> dout falls without waiting for a clock. After release plus a start pulse, ram_addr begins at 0.
